// File: rtl/mips_defs.sv
// Shared constants for the MIPS pipeline: bubble encoding, reset vector, IF error bits.
package mips_defs;

    localparam logic [31:0]   NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned   IF_ERR_MISALIGN  = 0;
    localparam int unsigned   IF_ERR_RANGE     = 1;
    localparam int unsigned   IF_ERR_W         = 2;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter with next-PC selection: redirect beats stall beats sequential +4.
module pc_reg
    import mips_defs::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4_c
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Sequential successor wraps silently modulo 2^WIDTH.
    assign pc_plus4_c = pc_q + WIDTH'(4);

    always_comb begin
        pc_d = pc_plus4_c;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, addresses irmemory and fills the IF/ID register.
module if_stage
    import mips_defs::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 1024,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [WIDTH-1:0]    redirect_pc,
    output logic [WIDTH-1:0]    imem_addr,
    input  logic [WIDTH-1:0]    imem_data,
    output logic [WIDTH-1:0]    pc,
    output logic [WIDTH-1:0]    ifid_pc,
    output logic [WIDTH-1:0]    ifid_pc4,
    output logic [WIDTH-1:0]    ifid_instr,
    output logic                ifid_valid,
    output logic [IF_ERR_W-1:0] ifid_err
);

    localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);

    logic [WIDTH-1:0]    pc_plus4_c;
    logic [IF_ERR_W-1:0] err_c;

    logic [WIDTH-1:0]    ifid_pc_q,    ifid_pc_d;
    logic [WIDTH-1:0]    ifid_pc4_q,   ifid_pc4_d;
    logic [WIDTH-1:0]    ifid_instr_q, ifid_instr_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [IF_ERR_W-1:0] ifid_err_q,   ifid_err_d;

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus4_c  (pc_plus4_c)
    );

    assign imem_addr = {2'b00, pc[WIDTH-1:2]};

    // Faults are only tagged here; the instruction still issues so decode can trap.
    always_comb begin
        err_c                  = '0;
        err_c[IF_ERR_MISALIGN] = |pc[1:0];
        err_c[IF_ERR_RANGE]    = (pc[WIDTH-1:2] >= DEPTH_W);
    end

    // Flush outranks stall so a squashed slot never lingers behind a hold.
    always_comb begin
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_err_d   = ifid_err_q;
        if (flush) begin
            ifid_pc_d    = pc;
            ifid_pc4_d   = pc_plus4_c;
            ifid_instr_d = WIDTH'(NOP_INSTR);
            ifid_valid_d = 1'b0;
            ifid_err_d   = '0;
        end else if (!stall) begin
            ifid_pc_d    = pc;
            ifid_pc4_d   = pc_plus4_c;
            ifid_instr_d = (err_c == '0) ? imem_data : WIDTH'(NOP_INSTR);
            ifid_valid_d = 1'b1;
            ifid_err_d   = err_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= '0;
            ifid_valid_q <= 1'b0;
            ifid_err_q   <= '0;
        end else begin
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_err_q   <= ifid_err_d;
        end
    end

    assign ifid_pc    = ifid_pc_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_err   = ifid_err_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; irmemory modelled as data = 0xA500_0000 | word index.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic        ifid_valid;
    logic [1:0]  ifid_err;

    int n_tests;
    int n_fail;

    if_stage #(
        .WIDTH    (32),
        .DEPTH    (1024),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .pc          (pc),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr),
        .ifid_valid  (ifid_valid),
        .ifid_err    (ifid_err)
    );

    assign imem_data = 32'hA500_0000 | imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        tick(); tick();
        chk("rst_pc",    pc,         32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_ifpc",  ifid_pc,    32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_err",   {30'b0, ifid_err},   32'h0);
        rst_n = 1'b1;
        chk("addr0", imem_addr, 32'h0);

        tick();
        chk("addr1",    imem_addr,  32'h1);
        chk("ifpc0",    ifid_pc,    32'h0);
        chk("instr0",   ifid_instr, 32'hA500_0000);
        chk("valid0",   {31'b0, ifid_valid}, 32'h1);
        tick();
        chk("addr2",    imem_addr,  32'h2);
        chk("ifpc4",    ifid_pc,    32'h4);
        chk("ifpc4_4",  ifid_pc4,   32'h8);
        tick();
        chk("ifpc8",    ifid_pc,    32'h8);
        tick();
        chk("pc10",     pc,         32'h10);

        // Stall three cycles at pc=0x10
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc",    pc,         32'h10);
            chk("stall_ifpc",  ifid_pc,    32'hC);
            chk("stall_instr", ifid_instr, 32'hA500_0003);
        end
        stall = 1'b0;
        tick();
        chk("unstall_pc",    pc,         32'h14);
        chk("unstall_ifpc",  ifid_pc,    32'h10);
        chk("unstall_instr", ifid_instr, 32'hA500_0004);
        tick();
        chk("unstall_ifpc2", ifid_pc,    32'h14);
        tick(); tick();
        chk("pc20",          pc,         32'h20);

        // Redirect with delay slot
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir_pc",    pc,         32'h100);
        chk("redir_addr",  imem_addr,  32'h40);
        chk("slot_ifpc",   ifid_pc,    32'h20);
        chk("slot_instr",  ifid_instr, 32'hA500_0008);
        chk("slot_valid",  {31'b0, ifid_valid}, 32'h1);
        tick();
        chk("tgt_ifpc",    ifid_pc,    32'h100);
        chk("tgt_instr",   ifid_instr, 32'hA500_0040);

        // Flush and stall together
        flush = 1'b1;
        stall = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
        chk("fs_pc",     pc,         32'h104);
        chk("fs_valid",  {31'b0, ifid_valid}, 32'h0);
        chk("fs_instr",  ifid_instr, 32'h0);
        chk("fs_ifpc",   ifid_pc,    32'h104);
        chk("fs_ifpc4",  ifid_pc4,   32'h108);
        tick();
        chk("post_fs_pc",    pc,         32'h108);
        chk("post_fs_instr", ifid_instr, 32'hA500_0041);

        // Misaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect = 1'b0;
        chk("mis_pc", pc, 32'h102);
        tick();
        chk("mis_err",   {30'b0, ifid_err},   32'h1);
        chk("mis_instr", ifid_instr, 32'h0);
        chk("mis_valid", {31'b0, ifid_valid}, 32'h1);
        chk("mis_ifpc",  ifid_pc,    32'h102);

        // Out-of-range target (word 0x400 == DEPTH)
        redirect    = 1'b1;
        redirect_pc = 32'h1000;
        tick();
        redirect = 1'b0;
        chk("rng_slot_err", {30'b0, ifid_err}, 32'h1);
        tick();
        chk("rng_err",   {30'b0, ifid_err},   32'h2);
        chk("rng_instr", ifid_instr, 32'h0);
        chk("rng_ifpc",  ifid_pc,    32'h1000);

        // Wrap at top of address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        chk("top_pc", pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc",    pc,       32'h0);
        chk("wrap_ifpc",  ifid_pc,  32'hFFFF_FFFC);
        chk("wrap_ifpc4", ifid_pc4, 32'h0);
        chk("wrap_err",   {30'b0, ifid_err}, 32'h2);
        tick();
        chk("wrap_ifpc0",  ifid_pc,    32'h0);
        chk("wrap_instr0", ifid_instr, 32'hA500_0000);
        chk("wrap_err0",   {30'b0, ifid_err}, 32'h0);
        tick(); tick();
        chk("pre_rst_pc", pc, 32'hC);

        // Asynchronous reset mid-run takes effect without a clock edge
        #1 rst_n = 1'b0;
        #1;
        chk("arst_pc",    pc,         32'h0);
        chk("arst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("arst_ifpc",  ifid_pc,    32'h0);
        chk("arst_instr", ifid_instr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_pc",    pc,      32'h4);
        chk("rel_ifpc",  ifid_pc, 32'h0);
        tick();
        chk("rel_ifpc4", ifid_pc, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
